// File: rtl/lsu_mem_stage_if.sv
// Word-wide memory bus between the load/store unit (master) and the memory system (slave).
interface lsu_mem_stage_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, we, addr, be, wdata, input ack, rdata);
   modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/lsu_mem_stage.sv
// MEMORY-stage load/store unit: sub-word alignment, LED toggle register,
// and a single-outstanding bus access that stalls the pipeline until done.
module lsu_mem_stage #(
   parameter logic [31:0] TOGGLE_ADDR = 32'd52,
   parameter logic [7:0]  TIMEOUT     = 8'd255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  MemReadM,
   input  logic                  MemWriteM,
   input  logic [2:0]            funct3M,
   input  logic [31:0]           ALUResultM,
   input  logic [31:0]           WriteDataM,
   output logic                  StallM,
   output logic [31:0]           ReadDataM,
   output logic [31:0]           toggle_value,
   output logic                  access_err,
   lsu_mem_stage_if.master       bus
);

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 8;

   typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

   state_t          state_q, state_d;
   logic            we_q;
   logic [DW-1:0]   addr_q;
   logic [1:0]      off_q;
   logic [3:0]      be_q;
   logic [DW-1:0]   wdata_q;
   logic [2:0]      f3_q;
   logic [CW-1:0]   cnt_q;
   logic [DW-1:0]   data_q;
   logic [DW-1:0]   toggle_q;

   logic            access, legal, aligned, valid, hit;
   logic [3:0]      be_c;
   logic [DW-1:0]   wdata_c;
   logic            stall_c, err_c, req_c;
   logic [DW-1:0]   rdata_c;
   logic            capture, toggle_we, ack_take, timeout;

   // Pick the addressed byte/half out of a word and extend it per funct3.
   function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = off[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  r = {{24{b[7]}}, b};
         3'b100:  r = {24'd0, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b101:  r = {16'd0, h};
         3'b010:  r = w;
         default: r = '0;
      endcase
      return r;
   endfunction

   // Request decode: legality, alignment, lane enables and replicated store data.
   always_comb begin
      access  = MemReadM | MemWriteM;
      legal   = 1'b0;
      aligned = 1'b1;
      be_c    = 4'b0000;
      wdata_c = WriteDataM;
      case (funct3M)
         3'b000, 3'b100: begin
            legal   = 1'b1;
            be_c    = 4'(4'b0001 << ALUResultM[1:0]);
            wdata_c = {4{WriteDataM[7:0]}};
         end
         3'b001, 3'b101: begin
            legal   = 1'b1;
            aligned = ~ALUResultM[0];
            be_c    = ALUResultM[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{WriteDataM[15:0]}};
         end
         3'b010: begin
            legal   = 1'b1;
            aligned = (ALUResultM[1:0] == 2'b00);
            be_c    = 4'b1111;
         end
         default: legal = 1'b0;
      endcase
      valid = access & legal & aligned;
      hit   = valid & (ALUResultM == TOGGLE_ADDR);
   end

   // Next-state and per-cycle control.
   always_comb begin
      state_d   = state_q;
      stall_c   = 1'b0;
      err_c     = 1'b0;
      req_c     = 1'b0;
      rdata_c   = '0;
      capture   = 1'b0;
      toggle_we = 1'b0;
      ack_take  = 1'b0;
      timeout   = 1'b0;
      case (state_q)
         IDLE: begin
            if (access && !valid) begin
               err_c = 1'b1;
            end else if (hit) begin
               if (MemWriteM) toggle_we = 1'b1;
               else           rdata_c   = toggle_q;
            end else if (valid) begin
               stall_c = 1'b1;
               capture = 1'b1;
               state_d = BUS;
            end
         end
         BUS: begin
            stall_c = 1'b1;
            if (cnt_q == TIMEOUT) begin
               timeout = 1'b1;
               err_c   = 1'b1;
               state_d = DONE;
            end else begin
               req_c = 1'b1;
               if (bus.ack) begin
                  ack_take = 1'b1;
                  state_d  = DONE;
               end
            end
         end
         DONE: begin
            if (!we_q) rdata_c = load_extend(f3_q, off_q, data_q);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Outputs are forced quiet for as long as reset is held.
      if (reset) begin
         stall_c = 1'b0;
         err_c   = 1'b0;
         req_c   = 1'b0;
         rdata_c = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         addr_q   <= '0;
         off_q    <= 2'd0;
         be_q     <= 4'd0;
         wdata_q  <= '0;
         f3_q     <= 3'd0;
         cnt_q    <= '0;
         data_q   <= '0;
         toggle_q <= '0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            we_q    <= MemWriteM;
            addr_q  <= {ALUResultM[31:2], 2'b00};
            off_q   <= ALUResultM[1:0];
            be_q    <= be_c;
            wdata_q <= wdata_c;
            f3_q    <= funct3M;
            cnt_q   <= '0;
         end else if (state_q == BUS) begin
            cnt_q <= CW'(cnt_q + 1'b1);
         end
         if (ack_take)     data_q <= we_q ? '0 : bus.rdata;
         else if (timeout) data_q <= '0;
         if (toggle_we) toggle_q <= WriteDataM;
      end
   end

   assign StallM       = stall_c;
   assign ReadDataM    = rdata_c;
   assign access_err   = err_c;
   assign toggle_value = toggle_q;
   assign bus.req      = req_c;
   assign bus.we       = we_q;
   assign bus.addr     = addr_q;
   assign bus.be       = be_q;
   assign bus.wdata    = wdata_q;

endmodule

// File: doc/lsu_mem_stage.md
LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

Interface
REQ-001 Parameter TOGGLE_ADDR, default 32'd52, byte address of the memory-mapped LED toggle register.
REQ-002 Parameter TIMEOUT, default 8'd255, maximum cycles to wait for bus_ack.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 MemReadM  in  1  load in MEMORY stage.
REQ-006 MemWriteM  in  1  store in MEMORY stage; has priority if both are high.
REQ-007 funct3M  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-008 ALUResultM  in  32  byte address.
REQ-009 WriteDataM  in  32  store data, LSB-aligned.
REQ-010 StallM  out  1  holds F/D/E/M pipeline registers while the access is outstanding.
REQ-011 ReadDataM  out  32  aligned, extended load result.
REQ-012 bus_req  out  1  bus request.
REQ-013 bus_we  out  1  bus write.
REQ-014 bus_addr  out  32  word-aligned address, ALUResultM with bits [1:0] = 00.
REQ-015 bus_be  out  4  byte enables.
REQ-016 bus_wdata  out  32  lane-replicated store data.
REQ-017 bus_ack  in  1  one-cycle completion strobe.
REQ-018 bus_rdata  in  32  read word, valid with bus_ack.
REQ-019 toggle_value  out  32  LED toggle register.
REQ-020 access_err  out  1  one-cycle error pulse.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, BUS and DONE.
REQ-022 An access is valid when (MemReadM | MemWriteM) is high, funct3M is a legal code, and the address is aligned: h/hu need addr[0]=0; w needs addr[1:0]=00.
REQ-023 Invalid access (illegal funct3 or misaligned): no bus activity, StallM=0, ReadDataM=0, access_err pulses one cycle, FSM stays IDLE, toggle_value unchanged.
REQ-024 Valid access with ALUResultM==TOGGLE_ADDR (toggle hit):
- store: toggle_value <= WriteDataM at the clock edge;
- load: ReadDataM = toggle_value, combinational;
- no bus activity, StallM=0, FSM stays IDLE.
REQ-025 Other valid access in IDLE: StallM=1 combinationally, then go to BUS.
REQ-026 In BUS: bus_req=1, StallM=1, and bus_we/addr/be/wdata are held stable until bus_ack.
REQ-027 bus_ack in BUS: bus_rdata is latched (loads only), go to DONE.
REQ-028 In DONE: StallM=0, ReadDataM is the extended latched data (0 for stores), return to IDLE; the request inputs are not re-evaluated in DONE.
REQ-029 Minimum latency with bus_ack in the first BUS cycle is 2 stall cycles (IDLE, BUS); each bus wait cycle adds one.
REQ-030 An 8-bit wait counter clears on entry to BUS and increments each BUS cycle.
REQ-031 If the wait counter reaches TIMEOUT without bus_ack:
- bus_req drops;
- access_err pulses;
- the latched data is forced to 0;
- go to DONE.
REQ-032 bus_be: b = 1<<addr[1:0]; h = 0011 if addr[1]=0, else 1100; w = 1111.
REQ-033 bus_wdata: b = {4{WriteDataM[7:0]}}; h = {2{WriteDataM[15:0]}}; w = WriteDataM.
REQ-034 Load extraction: select the byte by addr[1:0] or the half by addr[1]; b/h sign-extend, bu/hu zero-extend, w passes through.
REQ-035 bus_ack outside BUS SHALL be ignored.
REQ-036 When ReadDataM is not defined by REQ-023/024/028, it SHALL be 0.

Reset
REQ-037 While reset is high, regardless of clk:
- state=IDLE, bus_req=0, StallM=0;
- toggle_value=0, ReadDataM=0, access_err=0;
- wait counter=0, latched data=0.
REQ-038 Reset asserted in BUS drops bus_req immediately; a bus_ack arriving after reset SHALL be ignored.

Verification
REQ-039 lw at 0x100, bus_ack in the first BUS cycle with bus_rdata=0xDEADBEEF: StallM high 2 cycles, bus_be=1111, ReadDataM=0xDEADBEEF in DONE.
REQ-040 lb at 0x103 with bus_rdata=0x80FF0000 and 3 wait cycles: StallM high 5 cycles, bus_be=1000, ReadDataM=0xFFFFFF80; the same with lbu gives 0x00000080.
REQ-041 sh at 0x202 with WriteDataM=0x1234ABCD: bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD, bus_addr=0x200.
REQ-042 sw at 52 with 0x1: toggle_value=0x1 next cycle, no bus_req, StallM=0; a following lw at 52 gives ReadDataM=0x1.
REQ-043 lw at 0x101: access_err pulses 1 cycle, no bus_req, StallM=0; a lw with no bus_ack for 255 cycles gives access_err, DONE, ReadDataM=0.
REQ-044 reset asserted during BUS: bus_req=0 immediately, state IDLE, toggle_value=0.
